tdm_demux21: RTL and testbench



---
 rtl/tdm_demux21.sv | 87 ++++++++
 tb/tb_tdm_demux21.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux21.sv
// rtl/tdm_demux21.sv - 2:1 TDM demultiplexer with frame-sync lock, pair output, sync errors and frame count
module tdm_demux21 #(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  din,
  input  logic          din_valid,
  input  logic          frame_sync,
  output logic [W-1:0]  z0,
  output logic [W-1:0]  z1,
  output logic          pair_valid,
  output logic          sel,
  output logic          locked,
  output logic          sync_err,
  output logic [CW-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    EXP0 = 2'd1,
    EXP1 = 2'd2
  } state_t;

  state_t       state;
  logic [W-1:0] hold0;

  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // Frame FSM: captures slot 0, emits the aligned pair on slot 1, flags protocol violations.
  // Pulses default low every cycle; idle cycles leave every other register untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      hold0      <= '0;
      z0         <= '0;
      z1         <= '0;
      pair_valid <= 1'b0;
      sync_err   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      pair_valid <= 1'b0;
      sync_err   <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (frame_sync) begin
              hold0 <= din;
              state <= EXP1;
            end
          end
          EXP0: begin
            if (frame_sync) begin
              hold0 <= din;
              state <= EXP1;
            end else begin
              sync_err <= 1'b1;
              state    <= HUNT;
            end
          end
          EXP1: begin
            if (frame_sync) begin
              // Early sync: the pending slot-0 word is stale, restart the frame on this word.
              sync_err <= 1'b1;
              hold0    <= din;
            end else begin
              z0         <= hold0;
              z1         <= din;
              pair_valid <= 1'b1;
              frame_cnt  <= frame_cnt + CNT_ONE;
              state      <= EXP0;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  // Status flags are pure decodes of the state register.
  always_comb begin
    sel    = (state == EXP1);
    locked = (state != HUNT);
  end

endmodule

// File: tb/tb_tdm_demux21.sv
// tb/tb_tdm_demux21.sv - scoreboard bench for tdm_demux21 with randomized and directed frames
module tb_tdm_demux21;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [W-1:0]  din;
  logic          din_valid;
  logic          frame_sync;
  logic [W-1:0]  z0;
  logic [W-1:0]  z1;
  logic          pair_valid;
  logic          sel;
  logic          locked;
  logic          sync_err;
  logic [CW-1:0] frame_cnt;

  tdm_demux21 #(.W(W), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .z0         (z0),
    .z1         (z1),
    .pair_valid (pair_valid),
    .sel        (sel),
    .locked     (locked),
    .sync_err   (sync_err),
    .frame_cnt  (frame_cnt)
  );

  typedef struct {
    int            cyc;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [CW-1:0] cnt;
  } pair_t;

  pair_t pair_q[$];
  int    err_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: "is a slot-0 word waiting", "are we locked", last delivered pair.
  logic          m_locked;
  logic          m_pend;
  logic [W-1:0]  m_hold;
  logic [W-1:0]  m_z0;
  logic [W-1:0]  m_z1;
  logic [CW-1:0] m_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT raises a pulse.
  always @(negedge clk) begin
    pair_t p;
    if (pair_valid === 1'b1 && sync_err === 1'b1) chk("pulse_overlap", 1, 0);
    if (pair_valid === 1'b1) begin
      if (pair_q.size() == 0) begin
        chk("pair_unexpected", 1, 0);
      end else begin
        p = pair_q.pop_front();
        chk("pair_cycle", cyc, p.cyc);
        chk("pair_z0", z0, p.a);
        chk("pair_z1", z1, p.b);
        chk("pair_cnt", frame_cnt, p.cnt);
      end
    end
    if (sync_err === 1'b1) begin
      if (err_q.size() == 0) chk("err_unexpected", 1, 0);
      else chk("err_cycle", cyc, err_q.pop_front());
    end
  end

  task automatic step(input logic v, input logic s, input logic [W-1:0] d, input logic r);
    din = d; din_valid = v; frame_sync = s; rst = r;
    if (r) begin
      m_locked = 0; m_pend = 0; m_hold = '0; m_z0 = '0; m_z1 = '0; m_cnt = '0;
    end else if (v) begin
      if (s) begin
        if (m_pend) err_q.push_back(cyc + 1);
        m_pend = 1; m_hold = d; m_locked = 1;
      end else if (m_pend) begin
        m_z0 = m_hold; m_z1 = d; m_cnt = m_cnt + 1'b1; m_pend = 0;
        pair_q.push_back('{cyc + 1, m_z0, m_z1, m_cnt});
      end else if (m_locked) begin
        err_q.push_back(cyc + 1);
        m_locked = 0;
      end
    end
    @(posedge clk); #1;
    chk("locked", locked, m_locked);
    chk("sel", sel, m_pend);
    chk("z0", z0, m_z0);
    chk("z1", z1, m_z1);
    chk("frame_cnt", frame_cnt, m_cnt);
  endtask

  task automatic do_reset();
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
  endtask

  initial begin
    int nv;
    logic v, s, r;
    rst = 1'b1; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
    m_locked = 0; m_pend = 0; m_hold = '0; m_z0 = '0; m_z1 = '0; m_cnt = '0;

    do_reset();
    chk("rst_pair_valid", pair_valid, 0);
    chk("rst_sync_err", sync_err, 0);

    // Back-to-back two frames
    step(1, 1, 8'h11, 0); step(1, 0, 8'h22, 0);
    step(1, 1, 8'h33, 0); step(1, 0, 8'h44, 0);
    step(0, 0, 8'h00, 0);
    chk("t1_z0", z0, 8'h33); chk("t1_z1", z1, 8'h44); chk("t1_cnt", frame_cnt, 2);

    // Same stream with gaps
    do_reset();
    step(1, 1, 8'h11, 0); step(0, 1, 8'hEE, 0); step(1, 0, 8'h22, 0); step(0, 0, 8'hEE, 0);
    step(1, 1, 8'h33, 0); step(0, 0, 8'hEE, 0); step(1, 0, 8'h44, 0); step(0, 1, 8'hEE, 0);
    chk("t2_z0", z0, 8'h33); chk("t2_z1", z1, 8'h44); chk("t2_cnt", frame_cnt, 2);

    // Unsynced start
    do_reset();
    step(1, 0, 8'h01, 0); step(1, 0, 8'h02, 0); step(1, 0, 8'h03, 0);
    chk("t3_locked", locked, 0);
    step(1, 1, 8'h5A, 0); step(1, 0, 8'hA5, 0);
    chk("t3_z0", z0, 8'h5A); chk("t3_z1", z1, 8'hA5);

    // Early sync in EXP1
    do_reset();
    step(1, 1, 8'h01, 0); step(1, 1, 8'h02, 0); step(1, 0, 8'h03, 0);
    chk("t4_z0", z0, 8'h02); chk("t4_z1", z1, 8'h03); chk("t4_cnt", frame_cnt, 1);

    // Missing sync in EXP0
    step(1, 0, 8'h77, 0);
    chk("t5_locked", locked, 0); chk("t5_z0", z0, 8'h02); chk("t5_cnt", frame_cnt, 1);

    // Counter wrap, then reset mid-frame
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 8'(i), 0); step(1, 0, 8'(i + 100), 0);
    end
    chk("t6_wrap", frame_cnt, 0);
    step(1, 1, 8'h9C, 0);
    step(1, 0, 8'h55, 1);
    chk("t6_rst_z0", z0, 0); chk("t6_rst_z1", z1, 0); chk("t6_rst_locked", locked, 0);
    chk("t6_rst_sel", sel, 0); chk("t6_rst_pv", pair_valid, 0);
    step(1, 0, 8'h3D, 0);
    chk("t6_drop_locked", locked, 0); chk("t6_drop_z1", z1, 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      s  = m_pend ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 5) != 0);
      r  = ($urandom_range(0, 99) == 0);
      step(v, s, 8'($urandom), r);
    end

    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    nv = pair_q.size();
    chk("pairs_left", nv, 0);
    nv = err_q.size();
    chk("errs_left", nv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
